multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath. It replaces the flat single-cycle decode path for builds where instruction and data memory share one port with variable latency.
- Decodes the latched instruction register contents and walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the register-file, ALU, memory and PC enables/selects each cycle.
- Sits between the IR/ALU flags and the shared memory port.

Parameters:
- XLEN, 32, instruction register width; only 32 is supported.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; the FSM re-enters IDLE immediately.
- instr  input  XLEN  IR contents; valid from DECODE onward.
- zero  input  1  ALU zero flag; valid in EXEC.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_we  output  1  write when 1, read when 0; qualified by mem_req.
- addr_sel  output  1  0 = PC, 1 = ALU result register.
- ir_write  output  1  latch memory read data into IR.
- pc_write  output  1  update PC.
- pc_src  output  1  0 = PC+4, 1 = branch target (old PC + imm).
- RegWrite  output  1  register-file write enable.
- ALUSrc  output  1  0 = rs2, 1 = immediate.
- ALU_control  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- MemtoReg  output  1  1 = load data, 0 = ALU result.
- signexselec  output  2  00 = I, 01 = S, 10 = B immediate.
- halted  output  1  illegal instruction trapped.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset: state=IDLE; all outputs 0; ALU_control=0000. IDLE always goes to FETCH on the next clk.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - Stay while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE. These three are Mealy outputs on mem_ready.
- DECODE: one cycle, no enables asserted. Classify opcode = instr[6:0]:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - anything else goes to HALT.
- EXEC, drives ALU controls:
  - R and I-ALU: ALUSrc=(I-ALU); control from funct3/funct7.
    - funct7[5] selects SUB/SRA for R-type; SRA for I-type.
    - For I-type funct3=000, funct7 is ignored (ADDI, never SUB).
    - Next state WB.
  - LOAD/STORE: ADD with ALUSrc=1; signexselec=00 for LOAD, 01 for STORE; next state MEM.
  - BRANCH: SUB with ALUSrc=0, signexselec=10.
    - funct3=000 (BEQ) is taken when zero=1; funct3=001 (BNE) is taken when zero=0.
    - If taken: pc_write=1, pc_src=1.
    - Next state FETCH.
    - Any other branch funct3 goes to HALT.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(STORE).
  - Wait for mem_ready.
  - On ready: LOAD goes to WB; STORE goes to FETCH.
  - mem_req stays high, with address and mem_we stable, until ready.
- WB: RegWrite=1, MemtoReg=(LOAD), one cycle, next state FETCH.
- HALT: halted=1, all enables 0; stays until reset.
- Latency with zero-wait memory, from FETCH entry to next FETCH entry:
  - R/I: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
- Each mem_ready low cycle adds 1 cycle.
- mem_ready outside FETCH/MEM is ignored.
- Default values of pc_write, ir_write, RegWrite, mem_req and mem_we in every state not listed above: 0.
- Reset asserted mid-request drops mem_req in the same cycle (asynchronous). No partial PC or register update may follow.

Optional Feature:
- Macro: MCFSM_PERF_EN.
- When defined, adds outputs cycle_cnt[PERF_W-1:0] and instret_cnt[PERF_W-1:0]:
  - cycle_cnt increments every clk while not in IDLE or HALT.
  - instret_cnt increments on the last cycle of each retired instruction: WB, STORE MEM ready, BRANCH EXEC.
  - Both wrap at 2^PERF_W and reset to 0.
- When undefined, the ports and logic are absent.

Test Plan:
- Reset held 3 cycles then released, zero-wait memory → IDLE, then FETCH with mem_req=1; all other outputs 0 during reset.
- instr=0x002081B3 (ADD x3,x1,x2), mem_ready=1 → states 1,2,3,5; ALU_control=0000, ALUSrc=0; RegWrite=1 in WB only; 4 cycles.
- instr=0x0040A183 (LW x3,4(x1)), mem_ready low 2 cycles in MEM → mem_req/addr_sel/mem_we=1/1/0 held 3 cycles; WB with MemtoReg=1; 7 cycles total.
- instr=0x00208463 (BEQ): zero=1 gives pc_write=1, pc_src=1 in EXEC; zero=0 gives pc_write=0. Both return to FETCH after 3 cycles.
- instr=0xFFFFFFFF → HALT after DECODE, halted=1, no further mem_req; reset clears halted.
- Reset asserted while MEM is waiting on a STORE → mem_req and mem_we drop immediately; no RegWrite/pc_write; restart goes through IDLE.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory port.
// Optional performance counters (cycle_cnt, instret_cnt) are built when MCFSM_PERF_EN is defined.
module multicycle_control_fsm #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instr,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_src,
    output logic            RegWrite,
    output logic            ALUSrc,
    output logic [3:0]      ALU_control,
    output logic            MemtoReg,
    output logic [1:0]      signexselec,
    output logic            halted,
    output logic [2:0]      state_o
`ifdef MCFSM_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic       illegal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       br_ok;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign f7b5              = instr[30];
    assign unused_instr_bits = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};
    assign state_o           = state_q;

    // I-type ignores funct7 for ADDI; only the shift-right pair uses bit 30 there.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic b30, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        alu_decode = op;
    endfunction

    always_comb begin
        cls_d   = C_R;
        illegal = 1'b0;
        case (opcode)
            OP_R:      cls_d = C_R;
            OP_I:      cls_d = C_I;
            OP_LOAD:   cls_d = C_LOAD;
            OP_STORE:  cls_d = C_STORE;
            OP_BRANCH: cls_d = C_BRANCH;
            default:   illegal = 1'b1;
        endcase
    end

    assign br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_taken = (funct3 == 3'b000) ? zero : !zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= C_R;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= cls_d;
        end
    end

    // Outputs decode from the state register; FETCH/MEM handshakes and branch resolve are Mealy.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrc      = 1'b0;
        ALU_control = ALU_ADD;
        MemtoReg    = 1'b0;
        signexselec = 2'b00;
        halted      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_R, C_I: begin
                        ALUSrc      = (cls_q == C_I);
                        ALU_control = alu_decode(funct3, f7b5, cls_q == C_R);
                        state_d     = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        ALUSrc      = 1'b1;
                        signexselec = (cls_q == C_STORE) ? 2'b01 : 2'b00;
                        state_d     = S_MEM;
                    end
                    C_BRANCH: begin
                        ALU_control = ALU_SUB;
                        signexselec = 2'b10;
                        if (!br_ok) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write = br_taken;
                            pc_src   = br_taken;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == C_STORE);
                if (mem_ready) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls_q == C_LOAD);
                state_d  = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MCFSM_PERF_EN
    logic [PERF_W-1:0] cycle_q, instret_q;
    logic              retire;

    assign retire = (state_q == S_WB)
                 || (state_q == S_MEM && cls_q == C_STORE && mem_ready)
                 || (state_q == S_EXEC && cls_q == C_BRANCH && br_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT) cycle_q <= cycle_q + 1'b1;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule
